// File: rtl/hub75_frame_source.sv
// Double-buffered pixel source for the HUB75 scan driver; banks swap only at a frame boundary.
// Optional build macro TEST_PATTERN_EN adds a test_mode input that substitutes a column test pattern.
module hub75_frame_source #(
  parameter int unsigned COLS      = 64,
  parameter int unsigned ROWS_HALF = 16,
  parameter int unsigned COL_W     = 7,
  parameter int unsigned ROW_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [COL_W-1:0] col,
  input  logic [ROW_W-1:0] rows,
`ifdef TEST_PATTERN_EN
  input  logic             test_mode,
`endif
  output logic             ready,
  output logic             R0in,
  output logic             G0in,
  output logic             B0in,
  output logic             R1in,
  output logic             G1in,
  output logic             B1in,
  input  logic             wr_en,
  input  logic [5:0]       wr_x,
  input  logic [4:0]       wr_y,
  input  logic [2:0]       wr_rgb,
  input  logic             swap_req,
  output logic             wr_busy,
  output logic             swap_ack,
  output logic             front_sel
);

  localparam int unsigned AW    = ROW_W + 6;
  localparam int unsigned DEPTH = 2 ** AW;

  localparam logic [1:0] S_EMPTY   = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_PENDING = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             front_q, front_d;
  logic             ack_q, ack_d;
  logic [ROW_W-1:0] rows_q;
  logic [2:0]       rgb0_q, rgb0_d;
  logic [2:0]       rgb1_q, rgb1_d;

  logic [2:0] mem_lo [2][DEPTH];
  logic [2:0] mem_hi [2][DEPTH];

  logic          boundary;
  logic          wr_x_ok;
  logic          wr_ok;
  logic          col_ok;
  logic          show;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] wr_addr;
  logic [2:0]    src_lo, src_hi;

  assign boundary = (rows_q == ROW_W'(ROWS_HALF - 1)) && (rows == '0);

  // A 6-bit wr_x can only exceed the panel width when COLS is narrower than 64.
  if (COLS < 64) begin : g_wr_x_chk
    assign wr_x_ok = ({26'd0, wr_x} < COLS);
  end else begin : g_wr_x_all
    assign wr_x_ok = 1'b1;
  end

  assign wr_ok   = wr_en && (state_q != S_PENDING) && wr_x_ok;
  assign wr_addr = {wr_y[ROW_W-1:0], wr_x};
  assign rd_addr = {rows, col[5:0]};
  assign col_ok  = (col < COL_W'(COLS));

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (wr_y[4]) mem_hi[~front_q][wr_addr] <= wr_rgb;
      else         mem_lo[~front_q][wr_addr] <= wr_rgb;
    end
  end

  function automatic logic [2:0] pattern(input logic [COL_W-1:0] c);
    if (c[3:0] == 4'd0)      return 3'b100;
    else if (c[2:0] == 3'd0) return 3'b010;
    else if (c[1:0] == 2'd0) return 3'b001;
    else if (c[0] == 1'b0)   return 3'b111;
    else                     return 3'b000;
  endfunction

  always_comb begin
    show   = (state_q != S_EMPTY);
    src_lo = mem_lo[front_q][rd_addr];
    src_hi = mem_hi[front_q][rd_addr];
`ifdef TEST_PATTERN_EN
    if (test_mode) begin
      show   = 1'b1;
      src_lo = pattern(col);
      src_hi = pattern(col);
    end
`else
    if (1'b0) src_lo = pattern(col);
`endif
    rgb0_d = (show && col_ok) ? src_lo : '0;
    rgb1_d = (show && col_ok) ? src_hi : '0;
  end

  always_comb begin
    state_d = state_q;
    front_d = front_q;
    ack_d   = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (swap_req) begin
          front_d = ~front_q;
          ack_d   = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (swap_req) state_d = S_PENDING;
      end
      S_PENDING: begin
        if (boundary) begin
          front_d = ~front_q;
          ack_d   = 1'b1;
          state_d = S_RUN;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
      front_q <= 1'b0;
      ack_q   <= 1'b0;
      rows_q  <= '0;
      rgb0_q  <= '0;
      rgb1_q  <= '0;
    end else begin
      state_q <= state_d;
      front_q <= front_d;
      ack_q   <= ack_d;
      rows_q  <= rows;
      rgb0_q  <= rgb0_d;
      rgb1_q  <= rgb1_d;
    end
  end

`ifdef TEST_PATTERN_EN
  assign ready = (state_q == S_EMPTY) && !test_mode;
`else
  assign ready = (state_q == S_EMPTY);
`endif
  assign wr_busy   = (state_q == S_PENDING);
  assign swap_ack  = ack_q;
  assign front_sel = front_q;
  assign {R0in, G0in, B0in} = rgb0_q;
  assign {R1in, G1in, B1in} = rgb1_q;

endmodule

// File: tb/tb_hub75_frame_source.sv
// Self-checking bench for hub75_frame_source: directed frame/swap scenarios plus randomized traffic
// compared every cycle against a panel-level reference model.
module tb_hub75_frame_source;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] col = '0;
  logic [3:0] rows = '0;
  logic       wr_en = 1'b0;
  logic [5:0] wr_x = '0;
  logic [4:0] wr_y = '0;
  logic [2:0] wr_rgb = '0;
  logic       swap_req = 1'b0;
`ifdef TEST_PATTERN_EN
  logic       test_mode = 1'b0;
`endif
  logic ready, R0in, G0in, B0in, R1in, G1in, B1in, wr_busy, swap_ack, front_sel;

  always #5 clk = ~clk;

  hub75_frame_source #(.COLS(64), .ROWS_HALF(16), .COL_W(7), .ROW_W(4)) dut (
    .clk(clk), .rst(rst), .col(col), .rows(rows),
`ifdef TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .ready(ready),
    .R0in(R0in), .G0in(G0in), .B0in(B0in),
    .R1in(R1in), .G1in(G1in), .B1in(B1in),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_rgb(wr_rgb),
    .swap_req(swap_req), .wr_busy(wr_busy), .swap_ack(swap_ack), .front_sel(front_sel)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: whole 64x32 panel per bank, plus "frame shown" / "swap waiting" flags.
  bit [2:0] m_mem [2][32][64];
  bit       m_front, m_has, m_pend, m_ack;
  int       m_prev_rows;
  bit [5:0] m_rgb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit [2:0] ref_pattern(input int c);
    if (c % 16 == 0)     return 3'b100;
    else if (c % 8 == 0) return 3'b010;
    else if (c % 4 == 0) return 3'b001;
    else if (c % 2 == 0) return 3'b111;
    else                 return 3'b000;
  endfunction

  task automatic model_reset();
    m_front = 1'b0; m_has = 1'b0; m_pend = 1'b0; m_ack = 1'b0;
    m_rgb = '0; m_prev_rows = 0;
  endtask

  task automatic model_edge();
    int  c = int'(col);
    int  r = int'(rows);
    bit  bnd = (m_prev_rows == 15) && (r == 0);
    if (!m_has || c >= 64) m_rgb = '0;
    else                   m_rgb = {m_mem[m_front][r][c], m_mem[m_front][r+16][c]};
`ifdef TEST_PATTERN_EN
    if (test_mode) m_rgb = (c >= 64) ? 6'd0 : {ref_pattern(c), ref_pattern(c)};
`endif
    if (wr_en && !m_pend) m_mem[!m_front][wr_y][wr_x] = wr_rgb;
    m_ack = 1'b0;
    if (!m_has) begin
      if (swap_req) begin m_has = 1'b1; m_front = !m_front; m_ack = 1'b1; end
    end else if (!m_pend) begin
      if (swap_req) m_pend = 1'b1;
    end else if (bnd) begin
      m_pend = 1'b0; m_front = !m_front; m_ack = 1'b1;
    end
    m_prev_rows = r;
  endtask

  task automatic check_outputs();
    bit exp_ready = !m_has;
`ifdef TEST_PATTERN_EN
    if (test_mode) exp_ready = 1'b0;
`endif
    check("rgb", {R0in, G0in, B0in, R1in, G1in, B1in}, m_rgb);
    check("ready", ready, exp_ready);
    check("wr_busy", wr_busy, m_pend);
    check("swap_ack", swap_ack, m_ack);
    check("front_sel", front_sel, m_front);
  endtask

  // One clock: model follows the edge, outputs are compared 1 ns later, strobes are cleared.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    wr_en    = 1'b0;
    swap_req = 1'b0;
  endtask

  task automatic write_px(input int x, input int y, input bit [2:0] rgb);
    wr_en = 1'b1; wr_x = 6'(x); wr_y = 5'(y); wr_rgb = rgb;
    cyc();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill_back();
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 64; x++)
        write_px(x, y, 3'($urandom));
  endtask

  initial begin
    do_reset();

    // Idle after reset: nothing shown yet.
    col = 7'd5; rows = 4'd3;
    cyc();
    check("t1_ready", ready, 1'b1);
    check("t1_rgb", {R0in, G0in, B0in, R1in, G1in, B1in}, 6'd0);
    check("t1_front", front_sel, 1'b0);
    check("t1_busy", wr_busy, 1'b0);

    fill_back();
    write_px(5, 3, 3'b101);
    write_px(5, 19, 3'b010);

    // First swap from EMPTY is immediate.
    swap_req = 1'b1;
    cyc();
    check("t2_ack", swap_ack, 1'b1);
    check("t2_front", front_sel, 1'b1);
    check("t2_ready", ready, 1'b0);
    cyc();
    check("t2_pixel", {R0in, G0in, B0in, R1in, G1in, B1in}, 6'b101010);

    fill_back();

    // Swap request mid-frame waits for the 15->0 row wrap; writes meanwhile are dropped.
    rows = 4'd7;
    swap_req = 1'b1;
    cyc();
    check("t3_busy", wr_busy, 1'b1);
    write_px(5, 3, ~m_mem[0][3][5]);
    for (int r = 8; r < 16; r++) begin
      rows = 4'(r);
      cyc();
      check("t3_wait", swap_ack, 1'b0);
    end
    rows = 4'd0;
    cyc();
    check("t3_ack", swap_ack, 1'b1);
    check("t3_front", front_sel, 1'b0);
    check("t3_busy_drop", wr_busy, 1'b0);
    rows = 4'd3; col = 7'd5;
    cyc();
    cyc();
    check("t3_ignored", {R0in, G0in, B0in}, m_mem[0][3][5]);

    // End-of-row latch slot blanks the outputs.
    rows = 4'd2; col = 7'd64;
    cyc();
    check("t4_blank", {R0in, G0in, B0in, R1in, G1in, B1in}, 6'd0);
    col = 7'd63;
    cyc();

    // Reset while a swap is pending, then the next request swaps at once.
    rows = 4'd7; swap_req = 1'b1;
    cyc();
    check("t5_pending", wr_busy, 1'b1);
    do_reset();
    check("t5_front", front_sel, 1'b0);
    check("t5_ready", ready, 1'b1);
    swap_req = 1'b1;
    cyc();
    check("t5_ack", swap_ack, 1'b1);
    check("t5_front1", front_sel, 1'b1);

`ifdef TEST_PATTERN_EN
    test_mode = 1'b1;
    for (int c = 0; c < 9; c++) begin
      col = (c == 8) ? 7'd16 : 7'(c);
      cyc();
      check("t6_pattern", {R0in, G0in, B0in}, ref_pattern((c == 8) ? 16 : c));
    end
    test_mode = 1'b0;
`endif

    // Randomized scan traffic with writes, swap pulses and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 4 == 0) rows = 4'((int'(rows) + 1) % 16);
      col      = 7'($urandom_range(0, 80));
      wr_en    = 1'($urandom);
      wr_x     = 6'($urandom);
      wr_y     = 5'($urandom);
      wr_rgb   = 3'($urandom);
      swap_req = ($urandom % 32 == 0);
      if ($urandom % 700 == 0) begin
        wr_en = 1'b0; swap_req = 1'b0;
        do_reset();
      end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
